// File: rtl/frame_reader.sv
// frame_reader
//
// Scan-out reader for double-buffered RGB332 frame buffers. Reads the buffer
// that is not being written in raster order, expands each pixel to 4-4-4 RGB
// and hands it to the display sink over a valid/ready handshake. The source
// buffer is latched only at frame start so a swap can never tear a frame.
//
// Ports:
//   Clk, Reset_n        clock (rising edge), asynchronous active-low reset
//   start               one-cycle frame start pulse, honoured only when idle
//   buffer_select       writer's select; 0 = buffer 0 is being written
//   frame_buffer_0_in   buffer 0 read data, valid one cycle after rd_en
//   frame_buffer_1_in   buffer 1 read data, valid one cycle after rd_en
//   rd_en, rd_addr      shared read strobe and linear address y*H_RES+x
//   pix_valid/pix_ready output handshake
//   pix_r/g/b           expanded colour of the head pixel
//   pix_sof, pix_eol    head pixel is address 0 / last pixel of a line
//   busy                frame in progress
//   frame_done          one-cycle pulse after the frame's last handshake
//
// Build option: define FRAME_READER_CONTINUOUS_EN to scan frames back to back
// without start pulses (busy then stays high until reset).

module frame_reader #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              buffer_select,
  input  logic [7:0]        frame_buffer_0_in,
  input  logic [7:0]        frame_buffer_1_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [3:0]        pix_r,
  output logic [3:0]        pix_g,
  output logic [3:0]        pix_b,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              busy,
  output logic              frame_done
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                src_sel_q, src_sel_d;
  logic                frame_done_q, frame_done_d;

  // Tags of the read issued last cycle, travelling with its returning data.
  logic                inf_q;
  logic                inf_sof_q;
  logic                inf_eol_q;
  logic                inf_last_q;
  logic                inf_src_q;

  // Skid buffer entry: {last, eol, sof, data[7:0]}
  logic [10:0]         fifo_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          occ_q;

  logic [2:0]          level;
  logic                issue;
  logic                push;
  logic                pop;
  logic                last_addr;
  logic [7:0]          rd_data;
  logic [10:0]         wr_entry;
  logic [10:0]         head;

  assign head      = fifo_q[rd_ptr_q];
  assign pix_valid = (occ_q != 2'd0);
  assign pop       = pix_valid && pix_ready;
  assign push      = inf_q;

  // Entries that will remain after this cycle's pop, plus data still in flight.
  // Counting the pop lets reads stay gapless when the sink takes every pixel,
  // while still guaranteeing the buffer never holds more than two entries.
  assign level     = {1'b0, occ_q} + {2'b00, inf_q} - {2'b00, pop};
  assign issue     = (state_q == S_ACTIVE) && (level < 3'd2);
  assign last_addr = (x_q == X_LAST) && (y_q == Y_LAST);

  assign rd_en   = issue;
  assign rd_addr = addr_q;
  assign busy    = (state_q != S_IDLE);

  // Source tag is carried with the read so a re-latch of src_sel at a frame
  // boundary cannot redirect data that is still returning.
  assign rd_data  = inf_src_q ? frame_buffer_0_in : frame_buffer_1_in;
  assign wr_entry = {inf_last_q, inf_eol_q, inf_sof_q, rd_data};

  assign pix_r      = {head[7:5], head[7]};
  assign pix_g      = {head[4:2], head[4]};
  assign pix_b      = {head[1:0], head[1:0]};
  assign pix_sof    = head[8];
  assign pix_eol    = head[9];
  assign frame_done = frame_done_q;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    src_sel_d    = src_sel_q;
    frame_done_d = pop && head[10];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ACTIVE;
          x_d       = '0;
          y_d       = '0;
          addr_d    = '0;
          src_sel_d = buffer_select;
        end
      end

      S_ACTIVE: begin
        if (issue) begin
          if (last_addr) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
`ifdef FRAME_READER_CONTINUOUS_EN
            src_sel_d = buffer_select;
`else
            state_d = S_DRAIN;
`endif
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end

      S_DRAIN: begin
        // The last-tagged pixel is the final entry; its pop empties the frame.
        if (pop && head[10]) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      src_sel_q    <= 1'b0;
      frame_done_q <= 1'b0;
      inf_q        <= 1'b0;
      inf_sof_q    <= 1'b0;
      inf_eol_q    <= 1'b0;
      inf_last_q   <= 1'b0;
      inf_src_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      src_sel_q    <= src_sel_d;
      frame_done_q <= frame_done_d;
      inf_q        <= issue;
      if (issue) begin
        inf_sof_q  <= (addr_q == '0);
        inf_eol_q  <= (x_q == X_LAST);
        inf_last_q <= last_addr;
        inf_src_q  <= src_sel_q;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
module tb_frame_reader;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 3;
  localparam int N  = H * V;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          start;
  logic          buffer_select;
  logic [7:0]    fb0, fb1;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          pix_valid;
  logic          pix_ready;
  logic [3:0]    pix_r, pix_g, pix_b;
  logic          pix_sof, pix_eol;
  logic          busy;
  logic          frame_done;

  frame_reader #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .start             (start),
    .buffer_select     (buffer_select),
    .frame_buffer_0_in (fb0),
    .frame_buffer_1_in (fb1),
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .pix_valid         (pix_valid),
    .pix_ready         (pix_ready),
    .pix_r             (pix_r),
    .pix_g             (pix_g),
    .pix_b             (pix_b),
    .pix_sof           (pix_sof),
    .pix_eol           (pix_eol),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  always #5 Clk = ~Clk;

  // Synchronous-read frame buffer models
  logic [7:0] mem0 [N];
  logic [7:0] mem1 [N];
  always @(posedge Clk) begin
    if (rd_en) begin
      fb0 <= mem0[rd_addr];
      fb1 <= mem1[rd_addr];
    end
  end

  typedef struct {
    logic [3:0] r, g, b;
    logic       sof, eol;
  } pix_t;

  pix_t q[$];
  int   checks   = 0;
  int   failures = 0;

  int   first_rd, last_rd, first_pix, last_pix, done_cyc, done_cnt, n_pix, n_rd;
  logic busy_at_done, busy_c1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic pix_t expand(input logic [7:0] p, input int a);
    pix_t e;
    e.r   = {p[7:5], p[7]};
    e.g   = {p[4:2], p[4]};
    e.b   = {p[1:0], p[1:0]};
    e.sof = (a == 0);
    e.eol = ((a % H) == H - 1);
    return e;
  endfunction

  // sel is buffer_select at frame start: 0 -> buffer 1 is read, 1 -> buffer 0
  task automatic push_frame(input logic sel);
    for (int a = 0; a < N; a++) begin
      q.push_back(expand(sel ? mem0[a] : mem1[a], a));
    end
  endtask

  task automatic run_frame(input int pct, input bit poke);
    int          exp_addr;
    bit          prev_stall;
    logic [13:0] prev_bus;
    bit          drain_poked;
    bit          finished;
    pix_t        e;
    exp_addr = 0; prev_stall = 0; prev_bus = '0; drain_poked = 0; finished = 0;
    first_rd = -1; last_rd = -1; first_pix = -1; last_pix = -1; done_cyc = -1;
    done_cnt = 0; n_pix = 0; n_rd = 0; busy_at_done = 1'bx; busy_c1 = 1'bx;
    for (int c = 0; c < 400 && !finished; c++) begin
      @(negedge Clk);
      start = (c == 0);
      if (poke && c == 4) begin
        start         = 1'b1;
        buffer_select = ~buffer_select;
      end
      if (poke && !drain_poked && n_rd == N && busy && c > 4) begin
        start       = 1'b1;
        drain_poked = 1;
      end
      pix_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      #1;
      if (c == 1) busy_c1 = busy;
      chk("occ_le_2", {31'd0, (dut.occ_q <= 2'd2)}, 32'd1);
      if (prev_stall) begin
        chk("hold_valid", {31'd0, pix_valid}, 32'd1);
        chk("hold_data", {18'd0, pix_r, pix_g, pix_b, pix_sof, pix_eol}, {18'd0, prev_bus});
      end
      if (rd_en) begin
        if (first_rd < 0) first_rd = c;
        last_rd = c;
        chk("rd_addr", {29'd0, rd_addr}, exp_addr);
        exp_addr++;
        n_rd++;
      end
      if (pix_valid && pix_ready) begin
        if (first_pix < 0) first_pix = c;
        last_pix = c;
        n_pix++;
        chk("pixel_expected", {31'd0, (q.size() > 0)}, 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("pix_rgb", {20'd0, pix_r, pix_g, pix_b}, {20'd0, e.r, e.g, e.b});
          chk("pix_sof", {31'd0, pix_sof}, {31'd0, e.sof});
          chk("pix_eol", {31'd0, pix_eol}, {31'd0, e.eol});
        end
      end
      if (frame_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc     = c;
          busy_at_done = busy;
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_bus   = {pix_r, pix_g, pix_b, pix_sof, pix_eol};
      if (done_cyc >= 0 && c >= done_cyc + 3) finished = 1;
    end
    start = 1'b0;
    chk("frame_timeout", {31'd0, finished}, 32'd1);
    chk("frame_done_count", done_cnt, 32'd1);
    chk("pixel_count", n_pix, N);
    chk("read_count", n_rd, N);
    chk("queue_empty", q.size(), 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"},      {31'd0, rd_en},      32'd0);
    chk({tag, "_rd_addr"},    {29'd0, rd_addr},    32'd0);
    chk({tag, "_pix_valid"},  {31'd0, pix_valid},  32'd0);
    chk({tag, "_pix_rgb"},    {20'd0, pix_r, pix_g, pix_b}, 32'd0);
    chk({tag, "_pix_sof"},    {31'd0, pix_sof},    32'd0);
    chk({tag, "_pix_eol"},    {31'd0, pix_eol},    32'd0);
    chk({tag, "_busy"},       {31'd0, busy},       32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    Reset_n = 1'b0; start = 1'b0; buffer_select = 1'b0; pix_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      mem1[i] = 8'(i);
      mem0[i] = 8'(8'hC0 + 3 * i);
    end
    repeat (2) @(negedge Clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge Clk);
    Reset_n = 1'b1;

    // Baseline latency/throughput frame from buffer 1
    push_frame(1'b0);
    run_frame(100, 0);
    chk("first_rd_cycle",   first_rd,  32'd1);
    chk("last_rd_cycle",    last_rd,   32'd8);
    chk("first_pix_cycle",  first_pix, 32'd3);
    chk("last_pix_cycle",   last_pix,  32'd10);
    chk("frame_done_cycle", done_cyc,  32'd11);
    chk("busy_cycle1",      {31'd0, busy_c1},      32'd1);
    chk("busy_at_done",     {31'd0, busy_at_done}, 32'd0);

    // Expansion corner values, expected colours as constants
    mem1[0] = 8'hFF; mem1[1] = 8'hE0; mem1[2] = 8'h03; mem1[3] = 8'h49;
    q.push_back('{r: 4'hF, g: 4'hF, b: 4'hF, sof: 1'b1, eol: 1'b0});
    q.push_back('{r: 4'hF, g: 4'h0, b: 4'h0, sof: 1'b0, eol: 1'b0});
    q.push_back('{r: 4'h0, g: 4'h0, b: 4'hF, sof: 1'b0, eol: 1'b0});
    q.push_back('{r: 4'h4, g: 4'h4, b: 4'h5, sof: 1'b0, eol: 1'b1});
    for (int a = 4; a < N; a++) q.push_back(expand(mem1[a], a));
    run_frame(100, 0);

    // Random back-pressure at 30% ready
    for (int i = 0; i < N; i++) mem1[i] = 8'($urandom_range(255));
    push_frame(1'b0);
    run_frame(30, 0);

    // buffer_select toggles mid-frame and start pulses in ACTIVE and DRAIN
    buffer_select = 1'b0;
    push_frame(1'b0);
    run_frame(100, 1);
    chk("sel_after_toggle", {31'd0, buffer_select}, 32'd1);
    push_frame(1'b1);
    run_frame(100, 0);

    // Reset mid-frame with the sink stalled
    buffer_select = 1'b0;
    @(negedge Clk); start = 1'b1; pix_ready = 1'b0;
    @(negedge Clk); start = 1'b0;
    repeat (4) @(negedge Clk);
    #1;
    chk("pre_reset_valid", {31'd0, pix_valid}, 32'd1);
    Reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge Clk);
    Reset_n = 1'b1;
    q.delete();
    push_frame(1'b0);
    run_frame(100, 0);
    chk("post_reset_first_pix", first_pix, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
